uart_tx_arbiter: RTL

- Shares one UART `transmitter` instance between NUM_REQ byte-stream requesters using round-robin arbitration.
- Each requester presents bytes on a valid/ready handshake, with a `last` flag marking message end.
- A granted requester keeps the transmitter until its last byte completes, so messages never interleave on the serial line.
- Drives the transmitter's `enabled`/`start`/`in`, consumes its `busy`/`done`, and flags a transmitter that never starts.

---
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte-stream requesters.
// Messages are never interleaved: the owner keeps the transmitter until its last byte completes.
module uart_tx_arbiter #(
   parameter  int NUM_REQ        = 4,
   parameter  int TIMEOUT_CYCLES = 1024,
   localparam int GW             = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_enabled,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_done,
   output logic [GW-1:0]        grant_id,
   output logic                 locked,
   input  logic                 err_clear,
   output logic                 err_timeout
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic [GW-1:0]        grant_id_q, grant_id_d;
   logic                 locked_q, locked_d;
   logic [GW-1:0]        ptr_q, ptr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic [GW-1:0]        sel;
   logic [GW-1:0]        idx;
   logic                 sel_found;
   logic [GW-1:0]        next_ptr;
   logic [NUM_REQ-1:0]   ready_raw;
   logic                 start_raw;
   logic                 byte_done;

   assign next_ptr = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

   // Open message pins the choice to its owner; otherwise search upward from the pointer.
   always_comb begin
      sel       = grant_id_q;
      sel_found = 1'b0;
      idx       = '0;
      if (locked_q) begin
         sel_found = req_valid[grant_id_q];
      end else begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = GW'((int'(ptr_q) + i) % NUM_REQ);
            if (req_valid[idx]) begin
               sel       = idx;
               sel_found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      grant_id_d = grant_id_q;
      locked_d   = locked_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      err_d      = err_q & ~err_clear;
      ready_raw  = '0;
      start_raw  = 1'b0;
      byte_done  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable && sel_found) begin
               ready_raw[sel] = 1'b1;
               tx_data_d      = req_data[{sel, 3'b000} +: 8];
               grant_id_d     = sel;
               locked_d       = ~req_last[sel];
               state_d        = START;
            end
         end
         START: begin
            start_raw = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (tx_busy) begin
               state_d = WAIT_DONE;
            end else if (tx_done) begin
               byte_done = 1'b1;
            end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               err_d    = 1'b1;
               locked_d = 1'b0;
               ptr_d    = next_ptr;
               state_d  = IDLE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) begin
               byte_done = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // A dropped enable at byte completion aborts the rest of the open message.
      if (byte_done) begin
         state_d = IDLE;
         if (!locked_q || !enable) begin
            locked_d = 1'b0;
            ptr_d    = next_ptr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_data_q  <= '0;
         grant_id_q <= '0;
         locked_q   <= 1'b0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
         locked_q   <= locked_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
      end
   end

   // Combinational outputs are gated by rst_n so the transmitter is released the instant reset asserts.
   assign req_ready   = rst_n ? ready_raw : '0;
   assign tx_start    = start_raw;
   assign tx_enabled  = rst_n & (enable | (state_q != IDLE));
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_id_q;
   assign locked      = locked_q;
   assign err_timeout = err_q;

endmodule
